// File: rtl/alu_switch_sequencer.sv
// Clocked, edge-detected operator front end for the 32-bit ALU core: loads A/B/op from
// switch presses, waits a settle window, captures result and flags, and drives the display bus.
module alu_switch_sequencer #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SETTLE      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:1]       sw,
  input  logic [WIDTH-1:0] input_data,
  input  logic [WIDTH-1:0] alu_f,
  input  logic             alu_zf,
  input  logic             alu_of,
  input  logic             alu_cf,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] output_data,
  output logic             busy,
  output logic             result_valid
);

  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [4:0]        sync_q [SYNC_STAGES];
  logic [4:0]        hist_q;
  logic [4:0]        press;
  logic [WIDTH-1:0]  f_q;
  logic [2:0]        flags_q;
  logic              view_flags_q;
  logic [WIDTH-1:0]  flag_word;

  // Synchroniser and history reset high so a switch held through reset is not a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '1;
      hist_q <= '1;
    end else begin
      sync_q[0] <= sw;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign press = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign busy  = (state_q == StWait);

  always_comb begin
    flag_word      = '0;
    flag_word[6:0] = {result_valid, alu_op, flags_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      f_q          <= '0;
      flags_q      <= '0;
      result_valid <= 1'b0;
      view_flags_q <= 1'b0;
      output_data  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (press[0]) alu_a <= input_data;
          if (press[1]) alu_b <= input_data;
          if (press[2]) begin
            alu_op  <= input_data[2:0];
            cnt_q   <= CntW'(SETTLE - 1);
            state_q <= StWait;
          end
          if (|press[2:0]) result_valid <= 1'b0;
        end
        StWait: begin
          // Loads are dropped here so the ALU inputs stay stable across the settle window.
          if (cnt_q == '0) begin
            f_q          <= alu_f;
            flags_q      <= {alu_cf, alu_of, alu_zf};
            result_valid <= 1'b1;
            state_q      <= StIdle;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase

      if (press[4])      view_flags_q <= 1'b1;
      else if (press[3]) view_flags_q <= 1'b0;

      output_data <= view_flags_q ? flag_word : f_q;
    end
  end

endmodule

// File: doc/alu_switch_sequencer.md
Name: alu_switch_sequencer

Overview:
- Operator-facing front end that sits directly upstream of the 32-bit ALU core.
- Turns slide-switch pulses into registered A, B and op loads, then waits a settle window and captures the ALU result and flags.
- Drives a 32-bit display/output bus with either the result or the flag word.
- Replaces the combinational switch-to-ALU path with a clocked, edge-detected sequencer.

Parameters:
- WIDTH, 32: operand/result width.
- SYNC_STAGES, 2: synchroniser flops per switch (minimum 2).
- SETTLE, 1: cycles the ALU output is allowed to settle before capture (minimum 1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sw  in  5  level switches [5:1]: 1=load A, 2=load B, 3=load op+start, 4=view result, 5=view flags.
- input_data  in  WIDTH  operand/op source bus.
- alu_f  in  WIDTH  ALU result.
- alu_zf  in  1  ALU zero flag.
- alu_of  in  1  ALU signed-overflow flag.
- alu_cf  in  1  ALU carry-out flag.
- alu_a  out  WIDTH  registered operand A to ALU.
- alu_b  out  WIDTH  registered operand B to ALU.
- alu_op  out  3  registered opcode to ALU.
- output_data  out  WIDTH  display bus.
- busy  out  1  high while in WAIT.
- result_valid  out  1  captured result corresponds to current A/B/op.

Behaviour:
- Reset (async, rst_n=0):
  - alu_a, alu_b, alu_op, captured F and flags, output_data = 0.
  - busy=0, result_valid=0, view=RESULT, state=IDLE.
  - Every synchroniser stage and edge-history flop resets to 1, so a switch held high through reset release is not a press.
  - Reset mid-WAIT aborts with no capture.
- Switch path:
  - Each sw[i] passes through SYNC_STAGES flops plus one history flop.
  - Press = synchronised 1 while history is 0.
  - Action registers on the (SYNC_STAGES+1)th rising clk edge after the first edge that samples sw[i] high.
  - A switch held high yields exactly one press. Release is ignored.
- State IDLE:
  - Press1: alu_a <= input_data.
  - Press2: alu_b <= input_data.
  - Press3: alu_op <= input_data[2:0], cnt <= SETTLE-1, state -> WAIT.
  - Any press1/2/3 clears result_valid on the same edge.
  - Simultaneous presses 1, 2 and 3 in one cycle are all honoured. Press3 latches the new A/B values in that same edge.
- State WAIT:
  - busy=1. Press1, press2 and press3 are dropped (not queued).
  - On each edge: if cnt==0, capture F<=alu_f and flags<={alu_cf,alu_of,alu_zf}, set result_valid=1, state -> IDLE. Otherwise cnt--.
  - With SETTLE=1, capture occurs on the edge after the press3 edge.
- View control (any state):
  - Press4 sets view=RESULT. Press5 sets view=FLAGS.
  - Simultaneous press4 and press5: FLAGS wins.
- output_data (registered, updates the edge after a view change or capture):
  - RESULT: captured F.
  - FLAGS: {zeros, result_valid, alu_op, cf, of, zf}, where bit0=zf, bit1=of, bit2=cf, bits5:3=op, bit6=result_valid.
- Width rules:
  - No arithmetic in this block; operands pass through unchanged.
  - input_data[WIDTH-1:3] is ignored on an op load.
- The ALU core is combinational on alu_a/alu_b/alu_op. This block never drives them combinationally from the switches.

Test Plan:
- Reset with sw=5'b11111 held, then release, hold 10 cycles: no load occurs, alu_a=0, output_data=0. Then lower all switches and raise sw[1] with input_data=0x0001_FFFF: alu_a=0x0001_FFFF exactly 3 edges later.
- Load A=0x0001_FFFF, B=0x0001_000F, op=4 with the bench ALU model (add): busy high for 1 cycle, output_data=0x0003_000E, result_valid=1. Press5: output_data=0x0000_0060 (valid=1, op=4, flags 0).
- A=0x0001_FFFF, B=0xFFF1_000F, op=5 (sub): F=0x0010_FFF0, cf per model. Then A=B=0x1234_5678, op=5: press5 shows zf=1.
- Set SETTLE=4. Press3, then press1 with 0xDEAD_BEEF during WAIT: busy lasts 4 cycles, alu_a unchanged, capture on the 4th edge.
- Assert rst_n=0 mid-WAIT: all outputs return to reset values immediately, and no capture follows after release.
- Hold sw[3] high for 20 cycles: exactly one WAIT/capture sequence. Press4 and press5 on the same cycle select the FLAGS view.
